// File: rtl/in_port_fifo_if.sv
// Input-port bundle between the external producer / datapath and in_port_fifo.
//   master : environment side (producer drives ext_data/ext_valid, datapath
//            drives InPortIn and observes the head word and status).
//   slave  : FIFO side.
// Signals: ext_data/ext_valid/ext_ready (producer handshake), InPortIn (load
// strobe), InPortData (head word), in_empty/in_full/in_count/underflow (status).
interface in_port_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  logic [DATA_WIDTH-1:0]    ext_data;
  logic                     ext_valid;
  logic                     ext_ready;
  logic                     InPortIn;
  logic [DATA_WIDTH-1:0]    InPortData;
  logic                     in_empty;
  logic                     in_full;
  logic [$clog2(DEPTH):0]   in_count;
  logic                     underflow;

  modport master (
    output ext_data, ext_valid, InPortIn,
    input  ext_ready, InPortData, in_empty, in_full, in_count, underflow
  );

  modport slave (
    input  ext_data, ext_valid, InPortIn,
    output ext_ready, InPortData, in_empty, in_full, in_count, underflow
  );
endinterface

// File: rtl/in_port_fifo.sv
// Buffered input-port source for the datapath `in` instruction.
// Ports:
//   clk  - system clock, rising edge
//   clr  - synchronous active-high reset
//   bus  - in_port_fifo_if.slave: producer valid/ready push, InPortIn strobe,
//          InPortData head word, empty/full/count status, sticky underflow.
// A word is consumed on the falling side of InPortIn (release), so the head
// word stays stable for the entire time the strobe is held high.
module in_port_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic         clk,
  input  logic         clr,
  in_port_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  strobe_q;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  underflow_q;

  logic full;
  logic empty;
  logic push;
  logic release_evt;
  logic pop;

  always_comb begin
    full        = (count == FULL_COUNT);
    empty       = (count == '0);
    push        = bus.ext_valid && !full;
    release_evt = strobe_q && !bus.InPortIn;
    pop         = release_evt && !empty;
  end

  // Storage has no reset; a push coinciding with clr is simply not written.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= bus.ext_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      strobe_q    <= 1'b0;
      last_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      strobe_q <= bus.InPortIn;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (release_evt && empty) begin
        underflow_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    bus.ext_ready  = !full;
    bus.in_empty   = empty;
    bus.in_full    = full;
    bus.in_count   = count;
    bus.underflow  = underflow_q;
    bus.InPortData = empty ? last_q : mem[rd_ptr];
  end
endmodule

// File: tb/tb_in_port_fifo.sv
module tb_in_port_fifo;
  logic clk = 1'b0;
  logic clr;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  in_port_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

  in_port_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe();
    bus.InPortIn = 1'b1;
    tick();
    bus.InPortIn = 1'b0;
    tick();
  endtask

  task automatic push1(input logic [31:0] d);
    bus.ext_data  = d;
    bus.ext_valid = 1'b1;
    tick();
    bus.ext_valid = 1'b0;
  endtask

  initial begin
    // Reset with a producer trying to push
    clr           = 1'b1;
    bus.ext_valid = 1'b1;
    bus.ext_data  = 32'hDEAD;
    bus.InPortIn  = 1'b0;
    tick();
    tick();
    chk("rst_data",  bus.InPortData, 32'h0);
    chk("rst_empty", 32'(bus.in_empty), 32'h1);
    chk("rst_count", 32'(bus.in_count), 32'h0);
    chk("rst_ready", 32'(bus.ext_ready), 32'h1);
    chk("rst_full",  32'(bus.in_full), 32'h0);
    chk("rst_uflow", 32'(bus.underflow), 32'h0);
    clr           = 1'b0;
    bus.ext_valid = 1'b0;
    tick();
    chk("rst_nothing_stored", 32'(bus.in_count), 32'h0);

    // Single word, strobe held 4 cycles
    push1(32'd50);
    chk("single_vis",   bus.InPortData, 32'd50);
    chk("single_count", 32'(bus.in_count), 32'h1);
    bus.InPortIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_hold_data",  bus.InPortData, 32'd50);
      chk("single_hold_count", 32'(bus.in_count), 32'h1);
    end
    bus.InPortIn = 1'b0;
    tick();
    chk("single_rel_empty", 32'(bus.in_empty), 32'h1);
    chk("single_rel_last",  bus.InPortData, 32'd50);
    chk("single_rel_uflow", 32'(bus.underflow), 32'h0);

    // Fill and block
    bus.ext_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.ext_data = 32'(i);
      tick();
    end
    bus.ext_data = 32'd5;
    chk("fill_full",  32'(bus.in_full), 32'h1);
    chk("fill_ready", 32'(bus.ext_ready), 32'h0);
    chk("fill_count", 32'(bus.in_count), 32'h4);
    tick();
    chk("fill_blocked", 32'(bus.in_count), 32'h4);
    chk("fill_head1", bus.InPortData, 32'd1);
    bus.InPortIn = 1'b1;
    tick();
    chk("fill_still_blocked", 32'(bus.in_count), 32'h4);
    bus.InPortIn = 1'b0;
    tick();
    chk("fill_pop1_count", 32'(bus.in_count), 32'h3);
    chk("fill_pop1_ready", 32'(bus.ext_ready), 32'h1);
    chk("fill_head2", bus.InPortData, 32'd2);
    bus.InPortIn = 1'b1;
    tick();
    bus.ext_valid = 1'b0;
    chk("fill_5_accepted", 32'(bus.in_count), 32'h4);
    chk("fill_head2_hold", bus.InPortData, 32'd2);
    bus.InPortIn = 1'b0;
    tick();
    for (int i = 3; i <= 5; i++) begin
      chk("fill_order", bus.InPortData, 32'(i));
      strobe();
    end
    chk("fill_drained", 32'(bus.in_empty), 32'h1);
    chk("fill_last",    bus.InPortData, 32'd5);

    // Wrap-around
    for (int i = 0; i < 10; i++) begin
      push1(32'h10 + 32'(i));
      chk("wrap_head", bus.InPortData, 32'h10 + 32'(i));
      strobe();
      chk("wrap_empty", 32'(bus.in_empty), 32'h1);
    end
    chk("wrap_uflow", 32'(bus.underflow), 32'h0);

    // Simultaneous push and pop
    push1(32'hA);
    push1(32'hB);
    chk("sim_pre_count", 32'(bus.in_count), 32'h2);
    chk("sim_headA", bus.InPortData, 32'hA);
    bus.InPortIn = 1'b1;
    tick();
    bus.InPortIn  = 1'b0;
    bus.ext_data  = 32'hC;
    bus.ext_valid = 1'b1;
    tick();
    bus.ext_valid = 1'b0;
    chk("sim_count", 32'(bus.in_count), 32'h2);
    chk("sim_headB", bus.InPortData, 32'hB);
    strobe();
    chk("sim_headC", bus.InPortData, 32'hC);
    chk("sim_count1", 32'(bus.in_count), 32'h1);
    strobe();
    chk("sim_empty", 32'(bus.in_empty), 32'h1);

    // Underflow, then reset mid-strobe
    strobe();
    chk("uf_set",   32'(bus.underflow), 32'h1);
    chk("uf_count", 32'(bus.in_count), 32'h0);
    chk("uf_last",  bus.InPortData, 32'hC);
    bus.InPortIn = 1'b1;
    tick();
    clr           = 1'b1;
    bus.ext_valid = 1'b1;
    bus.ext_data  = 32'hEE;
    tick();
    chk("mid_rst_uflow", 32'(bus.underflow), 32'h0);
    chk("mid_rst_count", 32'(bus.in_count), 32'h0);
    chk("mid_rst_data",  bus.InPortData, 32'h0);
    clr           = 1'b0;
    bus.InPortIn  = 1'b0;
    bus.ext_data  = 32'hD;
    tick();
    bus.ext_valid = 1'b0;
    chk("post_rst_no_pop",   32'(bus.in_count), 32'h1);
    chk("post_rst_no_uflow", 32'(bus.underflow), 32'h0);
    chk("post_rst_head",     bus.InPortData, 32'hD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
